// File: rtl/port_switch_pkg.sv
// rtl/port_switch_pkg.sv - shared widths, lane types and destination decode for the 4-port switch
package port_switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int DEST_LSB  = 0;

  typedef logic [DATA_W-1:0]    lane_data_t;
  typedef logic [ADDR_W-1:0]    lane_addr_t;
  typedef logic [1:0]           port_idx_t;
  typedef logic [NUM_PORTS-1:0] port_mask_t;

  // Destination output lane carried in the address word
  function automatic port_idx_t dest_of(input lane_addr_t addr);
    return addr[DEST_LSB +: 2];
  endfunction

endpackage

// File: rtl/port_switch_core_rr_arbiter.sv
// rtl/port_switch_core_rr_arbiter.sv - round-robin arbiter for one output lane, owns its pointer
module rr_arbiter
  import port_switch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  port_mask_t req,
  output port_mask_t grant,
  output logic       grant_valid
);

  port_idx_t ptr_q;
  port_idx_t ptr_d;
  port_idx_t idx;

  // Search upward from the pointer, wrapping through the 2-bit index; first requester wins
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    ptr_d       = ptr_q;
    idx         = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr_q + port_idx_t'(k);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        ptr_d       = idx + 2'd1;
      end
    end
  end

  // Pointer moves past the winner only when something was granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/port_switch_core.sv
// rtl/port_switch_core.sv - 4-port switch core: one-entry input buffers, per-output round-robin, registered outputs
module port_switch_core
  import port_switch_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  input  logic [NUM_PORTS-1:0]        valid_in,
  output logic [NUM_PORTS-1:0]        data_read,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS*ADDR_W-1:0] addr_out,
  output logic [NUM_PORTS-1:0]        data_rdy
);

  port_mask_t full_q;
  port_mask_t full_d;
  port_mask_t read_q;
  lane_data_t buf_data_q [NUM_PORTS];
  lane_addr_t buf_addr_q [NUM_PORTS];

  port_mask_t req [NUM_PORTS];
  port_mask_t grant [NUM_PORTS];
  port_mask_t grant_valid;
  port_mask_t served;

  lane_data_t win_data [NUM_PORTS];
  lane_addr_t win_addr [NUM_PORTS];
  lane_data_t dout_q [NUM_PORTS];
  lane_addr_t aout_q [NUM_PORTS];
  port_mask_t rdy_q;

  // Request matrix: output j sees every full buffer whose destination is j
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      req[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[j][i] = full_q[i] && (dest_of(buf_addr_q[i]) == port_idx_t'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_arbiter u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         (req[j]),
      .grant       (grant[j]),
      .grant_valid (grant_valid[j])
    );
  end

  // An input has one destination, so at most one output can serve it per cycle
  always_comb begin
    served = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      served = served | grant[j];
    end
  end

  // Buffer occupancy: drain on grant, fill from an empty slot; never both on one edge
  always_comb begin
    full_d = full_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (full_q[i] && served[i]) begin
        full_d[i] = 1'b0;
      end else if (!full_q[i] && valid_in[i]) begin
        full_d[i] = 1'b1;
      end
    end
  end

  // Input buffers capture only while empty; data_read is a flop tracking emptiness
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      read_q <= '1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        buf_data_q[i] <= '0;
        buf_addr_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      read_q <= ~full_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!full_q[i] && valid_in[i]) begin
          buf_data_q[i] <= data_in[i*DATA_W +: DATA_W];
          buf_addr_q[i] <= addr_in[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // One-hot grant selects the winning buffer for each output lane
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      win_data[j] = '0;
      win_addr[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[j][i]) begin
          win_data[j] = buf_data_q[i];
          win_addr[j] = buf_addr_q[i];
        end
      end
    end
  end

  // Output lanes load only on a grant, so a lane never changes without its strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        dout_q[j] <= '0;
        aout_q[j] <= '0;
      end
    end else begin
      rdy_q <= grant_valid;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (grant_valid[j]) begin
          dout_q[j] <= win_data[j];
          aout_q[j] <= win_addr[j];
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    assign data_out[j*DATA_W +: DATA_W] = dout_q[j];
    assign addr_out[j*ADDR_W +: ADDR_W] = aout_q[j];
  end

  assign data_rdy  = rdy_q;
  assign data_read = read_q;

endmodule

// File: doc/port_switch_core.md
Name: port_switch_core

Overview:
- Core of the 4-port packet switch: accepts 16-bit data/address words on four input lanes and routes each to the output lane selected by its address.
- Drives the output lanes data_out, addr_out and data_rdy, which are the signals checked by the team's output assertion module.
- Each output arbitrates round-robin among contending inputs.
- An output lane changes only in a cycle where its data_rdy bit is high.

Parameters:
NUM_PORTS, 4, number of input and output lanes (design and bench exercised at 4 only)
DATA_W, 16, data word width per lane
ADDR_W, 16, address word width per lane
DEST_LSB, 0, LSB of the 2-bit destination field within each address word

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  NUM_PORTS*DATA_W  input data lanes, lane i = [i*16+15:i*16]
addr_in  input  NUM_PORTS*ADDR_W  input address lanes; destination = addr[DEST_LSB+1:DEST_LSB]
valid_in  input  NUM_PORTS  per-input request, qualifies data_in/addr_in lane
data_read  output  NUM_PORTS  per-input ready; registered; high = input buffer empty
data_out  output  NUM_PORTS*DATA_W  output data lanes
addr_out  output  NUM_PORTS*ADDR_W  output address lanes (full original address word)
data_rdy  output  NUM_PORTS  per-output strobe, one cycle per delivered word

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is clk; reset port is reset.
- Reset values:
  - data_out = 0, addr_out = 0, data_rdy = 0, data_read = 4'hF.
  - All input buffers empty; all round-robin pointers = 0.
- Reset mid-operation discards buffered words. No data_rdy pulses until the first word is accepted after reset deasserts.
- Input side, per lane i, one-entry buffer with states EMPTY and FULL:
  - EMPTY: data_read[i] = 1. At an edge with valid_in[i] = 1, capture data_in/addr_in lane i and go FULL.
  - FULL: data_read[i] = 0; valid_in[i] and lane data are ignored. Return to EMPTY at the edge where this buffer is granted.
  - data_read is a flop equal to ~FULL, so there is no same-edge refill. Sustained rate is 1 word per 2 cycles per input; this is intended.
- Arbitration, per output j:
  - Request set = inputs whose buffer is FULL and whose destination is j.
  - Combinational round-robin: search starts at ptr[j] and goes upward modulo 4; first requester wins.
  - On a grant, ptr[j] <= winner+1 mod 4. With no grant, ptr[j] is unchanged.
- Output, per output j, at the grant edge:
  - Lane j of data_out/addr_out <= the winner's buffered words.
  - data_rdy[j] <= 1, and the winner's buffer clears.
  - Edge with no grant: data_rdy[j] <= 0 and lane j holds its value.
  - Back-to-back grants keep data_rdy[j] high with new data each cycle.
  - A word equal to the previous one still produces a pulse.
- Latency: valid_in accepted at edge N → data_rdy visible after edge N+1 (2 cycles from valid to strobe) when there is no contention.
- Each input has a single destination, so an input is granted by at most one output per cycle. Different outputs grant independently in the same cycle (up to 4'hF).
- Output lanes have no backpressure; the downstream always accepts.
- Starvation bound: a FULL buffer is granted within 4 cycles.
- Invariant: lane j of data_out/addr_out differs from its previous-cycle value only if data_rdy[j] = 1 in that cycle.

Decomposition:
- Package port_switch_pkg:
  - NUM_PORTS, DATA_W, ADDR_W, DEST_LSB.
  - Typedefs lane_data_t, lane_addr_t, port_idx_t (2 bits), port_mask_t (NUM_PORTS bits).
  - Function dest_of(lane_addr_t) returning port_idx_t.
- Sub-module rr_arbiter:
  - Inputs: clk, reset, port_mask_t req.
  - Outputs: one-hot grant and grant_valid.
  - Owns the pointer.
  - Instantiated once per output.

Test Plan:
1. Assert reset while three buffers are FULL and data_rdy = 4'b0010 → immediately data_rdy = 0, data_out = 0, addr_out = 0, data_read = 4'hF. No strobes until a new valid_in is sent.
2. Input 0 sends data 16'hABCD, addr 16'h0002 for one cycle → two edges later data_rdy = 4'b0100, data_out[47:32] = 16'hABCD, addr_out[47:32] = 16'h0002. Strobe lasts one cycle; other lanes stay unchanged.
3. All four inputs send to destination 1 in the same cycle after reset → data_rdy[1] is high for 4 consecutive cycles with sources in order input 0, 1, 2, 3. data_read[k] returns high the cycle after input k is served.
4. Inputs 0–3 send to destinations 3, 2, 1, 0 in the same cycle → data_rdy = 4'hF in one cycle, with lanes carrying the data in reversed order.
5. Input 2 holds valid_in high, changing data every cycle, while FULL and blocked by contention → data_read[2] = 0. Only the word captured on the EMPTY→FULL edge appears on the output.
6. After a delivery to lane 3, idle for 20 cycles → lane 3 is constant and data_rdy[3] = 0 throughout. Resending an identical word → one more pulse with unchanged lane values.
